updown_btn_ctrl: RTL and testbench

- Front-end controller for the 4-bit up/down LED counter.
- Synchronises and debounces the raw up/down buttons, then arbitrates between them with a 4-state FSM.
- Issues single-cycle increment/decrement command pulses that the counter datapath consumes at full CLOCK rate, replacing the slow divided-clock sampling.
- Sits between the board buttons and the counter register; the counter performs `+1`/`-1` on the respective pulse.

---
 rtl/updown_btn_ctrl_pkg.sv | 16 +
 rtl/updown_btn_ctrl_debounce.sv | 43 ++++
 rtl/updown_btn_ctrl.sv | 146 ++++++++++++++
 tb/tb_updown_btn_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_btn_ctrl_pkg.sv
// Shared FSM state type and default timing constants for the up/down button front end.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_HELD  = 2'd1,
    DN_HELD  = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  localparam int DEF_DB_CYCLES     = 1250000;
  localparam int DEF_REPEAT_DELAY  = 62500000;
  localparam int DEF_REPEAT_PERIOD = 12500000;
  localparam int DEF_CNT_W         = 27;

endpackage

// File: rtl/updown_btn_ctrl_debounce.sv
// One button lane: 2-FF synchroniser followed by a stable-level debounce counter.
module btn_debounce
  import updown_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic CLOCK,
  input  logic Rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1, r_sync2, r_level;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any return to the accepted level restarts the stability window.
  always_ff @(posedge CLOCK or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;

endmodule

// File: rtl/updown_btn_ctrl.sv
// Up/down button controller: debounced buttons feed a 4-state arbiter issuing 1-cycle count pulses.
// Optional auto-repeat while a button is held: define UPDOWN_AUTO_REPEAT_EN.
module updown_btn_ctrl
  import updown_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       CLOCK,
  input  logic       Rst,
  input  logic       upBttn,
  input  logic       dwnBttn,
  output logic       cnt_up,
  output logic       cnt_dn,
  output logic       conflict,
  output logic [1:0] state
);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("updown_btn_ctrl: illegal timing parameters");
  end

  logic [1:0] w_raw, w_lvl;
  logic       w_u, w_d;

  assign w_raw = {dwnBttn, upBttn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .CLOCK (CLOCK),
      .Rst   (Rst),
      .raw   (w_raw[gi]),
      .level (w_lvl[gi])
    );
  end

  assign w_u = w_lvl[0];
  assign w_d = w_lvl[1];

  state_t r_state;
  logic   r_up, r_dn, r_conflict;

`ifdef UPDOWN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
  logic [CNT_W-1:0] w_rpt_last;

  assign w_rpt_last = r_rpt_first ? RD_LAST : RP_LAST;
`endif

  always_ff @(posedge CLOCK or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_up       <= 1'b0;
      r_dn       <= 1'b0;
      r_conflict <= 1'b0;
`ifdef UPDOWN_AUTO_REPEAT_EN
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
`endif
    end else begin
      r_up <= 1'b0;
      r_dn <= 1'b0;
`ifdef UPDOWN_AUTO_REPEAT_EN
      // Re-armed every cycle unless a held state keeps counting below.
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
`endif
      case (r_state)
        IDLE: begin
          if (w_u && w_d) begin
            r_state    <= CONFLICT;
            r_conflict <= 1'b1;
          end else if (w_u) begin
            r_state <= UP_HELD;
            r_up    <= 1'b1;
          end else if (w_d) begin
            r_state <= DN_HELD;
            r_dn    <= 1'b1;
          end
        end
        UP_HELD: begin
          if (!w_u && !w_d) begin
            r_state <= IDLE;
          end else if (w_d) begin
            r_state    <= CONFLICT;
            r_conflict <= 1'b1;
          end else begin
`ifdef UPDOWN_AUTO_REPEAT_EN
            if (r_rpt_cnt == w_rpt_last) begin
              r_up        <= 1'b1;
              r_rpt_first <= 1'b0;
            end else begin
              r_rpt_cnt   <= r_rpt_cnt + CNT_W'(1);
              r_rpt_first <= r_rpt_first;
            end
`endif
          end
        end
        DN_HELD: begin
          if (!w_u && !w_d) begin
            r_state <= IDLE;
          end else if (w_u) begin
            r_state    <= CONFLICT;
            r_conflict <= 1'b1;
          end else begin
`ifdef UPDOWN_AUTO_REPEAT_EN
            if (r_rpt_cnt == w_rpt_last) begin
              r_dn        <= 1'b1;
              r_rpt_first <= 1'b0;
            end else begin
              r_rpt_cnt   <= r_rpt_cnt + CNT_W'(1);
              r_rpt_first <= r_rpt_first;
            end
`endif
          end
        end
        CONFLICT: begin
          // Only a full release clears the conflict; a partial release stays silent.
          if (!w_u && !w_d) begin
            r_state    <= IDLE;
            r_conflict <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_conflict <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_up   = r_up;
  assign cnt_dn   = r_dn;
  assign conflict = r_conflict;
  assign state    = r_state;

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Scoreboard bench for updown_btn_ctrl; repeat expectations follow UPDOWN_AUTO_REPEAT_EN.
module tb_updown_btn_ctrl;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 3;

  logic       CLOCK = 1'b0;
  logic       Rst, upBttn, dwnBttn;
  logic       cnt_up, cnt_dn, conflict;
  logic [1:0] state;

  updown_btn_ctrl #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .CNT_W         (8)
  ) dut (
    .CLOCK    (CLOCK),
    .Rst      (Rst),
    .upBttn   (upBttn),
    .dwnBttn  (dwnBttn),
    .cnt_up   (cnt_up),
    .cnt_dn   (cnt_dn),
    .conflict (conflict),
    .state    (state)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit up;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLOCK);
  endtask

  // np: cycle the press is driven; nx: cycle the release/interrupting event is driven.
  // The FSM still evaluates the held level up to edge nx+DB+2.
  task automatic expect_hold(input int np, input int nx, input bit up);
    exp_t e;
    e.cyc = np + LAT;
    e.up  = up;
    q.push_back(e);
`ifdef UPDOWN_AUTO_REPEAT_EN
    for (int t = np + LAT + RD; t <= nx + DB + 2; t += RP) begin
      e.cyc = t;
      q.push_back(e);
    end
`else
    if (nx < np) $display("note: release precedes press");
`endif
  endtask

  // Monitor: every presented pulse is checked against the head of the queue.
  always @(negedge CLOCK) begin
    exp_t e;
    if (!Rst && (cnt_up || cnt_dn)) begin
      if (cnt_up && cnt_dn) begin
        chk("both_pulses", 32'd1, 32'd0);
      end else if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL stray_pulse: got up=%0b dn=%0b at cycle %0d, expected none", cnt_up, cnt_dn, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_dir_up", {31'd0, cnt_up}, {31'd0, e.up});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    int n, m;
    Rst = 1'b1; upBttn = 1'b0; dwnBttn = 1'b0;
    repeat (3) @(negedge CLOCK);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_up", {31'd0, cnt_up}, 32'd0);
    chk("reset_dn", {31'd0, cnt_dn}, 32'd0);
    chk("reset_conflict", {31'd0, conflict}, 32'd0);
    Rst = 1'b0;
    wait_until(cyc + 5);

    // single clean press
    n = cyc;
    expect_hold(n, n + 20, 1'b1);
    upBttn = 1'b1;
    wait_until(n + LAT - 1);
    chk("single_state_pre", {30'd0, state}, 32'd0);
    wait_until(n + LAT);
    chk("single_state_up", {30'd0, state}, 32'd1);
    wait_until(n + 20);
    upBttn = 1'b0;
    wait_until(n + 28);
    chk("single_state_idle", {30'd0, state}, 32'd0);
    wait_until(n + 35);

    // bounce, then settle high
    n = cyc;
    upBttn = 1'b1; wait_until(n + 2);
    upBttn = 1'b0; wait_until(n + 4);
    upBttn = 1'b1; wait_until(n + 6);
    upBttn = 1'b0; wait_until(n + 8);
    chk("bounce_no_accept", {30'd0, state}, 32'd0);
    expect_hold(n + 8, n + 20, 1'b1);
    upBttn = 1'b1;
    wait_until(n + 20);
    upBttn = 1'b0;
    wait_until(n + 35);

    // simultaneous press
    n = cyc;
    upBttn = 1'b1; dwnBttn = 1'b1;
    wait_until(n + 20);
    chk("simul_state", {30'd0, state}, 32'd3);
    chk("simul_conflict", {31'd0, conflict}, 32'd1);
    dwnBttn = 1'b0;
    wait_until(n + 32);
    chk("simul_partial_state", {30'd0, state}, 32'd3);
    upBttn = 1'b0;
    wait_until(n + 42);
    chk("simul_release_state", {30'd0, state}, 32'd0);
    chk("simul_release_conflict", {31'd0, conflict}, 32'd0);

    // down pressed, up joins 10 cycles later
    n = cyc;
    expect_hold(n, n + 10, 1'b0);
    dwnBttn = 1'b1;
    wait_until(n + 10);
    upBttn = 1'b1;
    wait_until(n + 20);
    chk("overlap_state", {30'd0, state}, 32'd3);
    chk("overlap_conflict", {31'd0, conflict}, 32'd1);
    upBttn = 1'b0; dwnBttn = 1'b0;
    wait_until(n + 30);
    chk("overlap_release_state", {30'd0, state}, 32'd0);

    // long down hold (repeat offsets 0,10,13..28 when enabled)
    n = cyc;
    expect_hold(n, n + 31, 1'b0);
    dwnBttn = 1'b1;
    wait_until(n + LAT);
    chk("hold_state_dn", {30'd0, state}, 32'd2);
    wait_until(n + 31);
    dwnBttn = 1'b0;
    wait_until(n + 45);
    chk("hold_release_state", {30'd0, state}, 32'd0);

    // reset mid-hold, button kept high through reset
    n = cyc;
    expect_hold(n, n + 9, 1'b1);
    upBttn = 1'b1;
    wait_until(n + 9);
    chk("prereset_state", {30'd0, state}, 32'd1);
    Rst = 1'b1;
    #1;
    chk("midreset_state", {30'd0, state}, 32'd0);
    chk("midreset_up", {31'd0, cnt_up}, 32'd0);
    chk("midreset_dn", {31'd0, cnt_dn}, 32'd0);
    chk("midreset_conflict", {31'd0, conflict}, 32'd0);
    wait_until(n + 12);
    Rst = 1'b0;
    m = cyc;
    expect_hold(m, m + 20, 1'b1);
    wait_until(m + LAT - 1);
    chk("postreset_state_pre", {30'd0, state}, 32'd0);
    wait_until(m + LAT);
    chk("postreset_state_up", {30'd0, state}, 32'd1);
    wait_until(m + 20);
    upBttn = 1'b0;
    wait_until(m + 35);
    chk("final_state", {30'd0, state}, 32'd0);

    chk("pending_pulses", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
